// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the single UART_CTRL transmit path between N_REQ on-chip requesters
// (command echo, status, ASIC readback). A round-robin arbiter picks one byte
// at a time. A requester that asserts req_lock on its accepted byte keeps
// ownership, so multi-byte packets are never interleaved. Each byte is
// handed to UART_CTRL with the TXDATA / TXCAPTURE / TXTRANSMIT handshake, and
// then the arbiter waits for the rising edge of TXSENT. A watchdog aborts a
// byte whose TXSENT never arrives and sets a sticky error flag.
//
// Parameters
//   N_REQ           number of requesters (2..8)
//   TIMEOUT_CYCLES  max clk cycles spent in WAIT before the byte is aborted
//
// Ports
//   clk          in   system clock (100 MHz)
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [N_REQ]    requester i presents a byte
//   req_lock     in   [N_REQ]    requester i keeps ownership after this byte
//   req_data     in   [8*N_REQ]  byte of requester i at [8i+7:8i]
//   req_ready    out  [N_REQ]    one-hot, combinational, IDLE only
//   req_done     out  [N_REQ]    one-cycle pulse: requester i's byte was sent
//   grant        out  [N_REQ]    one-hot current owner, 0 when none
//   txdata       out  [8]        to UART_CTRL.TXDATA (registered)
//   txcapture    out             to UART_CTRL.TXCAPTURE, one-cycle pulse
//   txtransmit   out             to UART_CTRL.TXTRANSMIT, one-cycle pulse
//   txsent       in              from UART_CTRL.TXSENT, rising edge = sent
//   busy         out             FSM is not in IDLE
//   timeout_err  out             sticky watchdog flag
//   err_clr      in              clears timeout_err on the next edge
//
// States
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | arbitrate; req_ready driven; accept a byte into txdata
//   ST_SETUP | one cycle with txdata stable before capture
//   ST_CAP   | txcapture high for one cycle
//   ST_XMIT  | txtransmit high for one cycle; watchdog loaded
//   ST_WAIT  | wait for txsent rising edge or watchdog terminal count
//------------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_lock,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           txdata,
  output logic                 txcapture,
  output logic                 txtransmit,
  input  logic                 txsent,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  // The watchdog is a down-counter: loaded in XMIT with TIMEOUT_CYCLES-1 and
  // checked for zero in WAIT, so WAIT lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CAP   = 3'd2,
    ST_XMIT  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    lock_id;
  logic             lock_vld;
  logic [CW-1:0]    wd_cnt;
  logic             txsent_q;

  logic             lock_hold;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] cand;
  logic             win_found;
  logic [IW-1:0]    win_id;
  logic [IW-1:0]    scan_id;
  logic [N_REQ-1:0] win_onehot;
  logic [7:0]       win_data;
  logic [IW-1:0]    rr_next;
  logic             txsent_rise;

  // The lock only restricts arbitration while the owner still asserts
  // req_lock; dropping it in IDLE reopens round-robin in the same cycle.
  assign lock_hold = lock_vld & req_lock[lock_id];

  always_comb begin
    elig = '0;
    for (int k = 0; k < N_REQ; k++) begin
      elig[k] = !lock_hold || (lock_id == IW'(k));
    end
  end

  assign cand = req_valid & elig;

  // First candidate at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && cand[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win_id;

  always_comb begin
    win_data = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == IW'(k)) begin
        win_data = req_data[8*k +: 8];
      end
    end
  end

  assign rr_next     = (win_id == LAST_ID) ? '0 : win_id + IW'(1);
  assign req_ready   = (state == ST_IDLE && win_found) ? win_onehot : '0;
  assign txsent_rise = txsent & ~txsent_q;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      lock_id     <= '0;
      lock_vld    <= 1'b0;
      wd_cnt      <= '0;
      txsent_q    <= 1'b0;
      txdata      <= 8'h00;
      txcapture   <= 1'b0;
      txtransmit  <= 1'b0;
      grant       <= '0;
      req_done    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // History is tracked in every state so a level left over from an
      // earlier byte never looks like a fresh edge once WAIT is reached.
      txsent_q   <= txsent;
      req_done   <= '0;
      txcapture  <= 1'b0;
      txtransmit <= 1'b0;

      // A watchdog set later in this block overrides this clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (lock_vld && !req_lock[lock_id]) begin
            lock_vld <= 1'b0;
            grant    <= '0;
          end
          if (win_found) begin
            txdata   <= win_data;
            grant    <= win_onehot;
            lock_vld <= req_lock[win_id];
            lock_id  <= win_id;
            rr_ptr   <= rr_next;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          txcapture <= 1'b1;
          state     <= ST_CAP;
        end

        ST_CAP: begin
          txtransmit <= 1'b1;
          state      <= ST_XMIT;
        end

        ST_XMIT: begin
          wd_cnt <= WD_LOAD;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          // A TXSENT edge in the terminal-count cycle still counts as sent.
          if (txsent_rise) begin
            req_done <= grant;
            state    <= ST_IDLE;
            if (!lock_vld) begin
              grant <= '0;
            end
          end else if (wd_cnt == '0) begin
            timeout_err <= 1'b1;
            lock_vld    <= 1'b0;
            grant       <= '0;
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt - CW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
